// File: rtl/out_port_pkg.sv
// out_port_pkg: shared definitions for the out-port transmitter.
//   DATA_W_DEF   default bus / port word width
//   os_state_e   output-stage state encoding
//   occ_width()  bit width needed to count 0..depth words
package out_port_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OS_EMPTY = 1'b0,
    OS_VALID = 1'b1
  } os_state_e;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/out_port_fifo.sv
// out_port_fifo: ENTRIES-deep synchronous FIFO, the body behind the tx stage.
//   clk, clr        clock, async active-low reset
//   push_i/wdata_i  enqueue request and word
//   pop_i           dequeue the head word
//   rdata_o         current head word (valid while empty_o is low)
//   full_o/empty_o  status
//   count_o         words held
// Pointers wrap modulo ENTRIES, which need not be a power of two.
module out_port_fifo #(
  parameter  int DATA_W  = 32,
  parameter  int ENTRIES = 3,
  localparam int CNT_W   = $clog2(ENTRIES + 1),
  localparam int PW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [ENTRIES];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(ENTRIES - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(ENTRIES));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/out_port_tx.sv
// out_port_tx: output-port peripheral for the `out` instruction.
//   clk, clr          clock, async active-low reset
//   OutPort_in        capture strobe, Bus_Data is the word to capture
//   out_full          registered full flag, stalls the control unit
//   Outport_Data_Out  last accepted word, held for polled devices
//   tx_data/tx_valid  head-of-queue word to the external device
//   tx_ready          external device accepts tx_data this cycle
//   occupancy         words held, tx stage included
//   overflow/ovf_clr  sticky dropped-write flag and its clear
//
// Output-stage FSM:
//   state    | meaning
//   OS_EMPTY | no word presented, tx_valid=0
//   OS_VALID | tx_data_q holds the head word, tx_valid=1
module out_port_tx
  import out_port_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 4,
  localparam int OCC_W  = occ_width(DEPTH),
  localparam int FCNT_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              OutPort_in,
  input  logic [DATA_W-1:0] Bus_Data,
  output logic              out_full,
  output logic [DATA_W-1:0] Outport_Data_Out,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [OCC_W-1:0]  occupancy,
  output logic              overflow,
  input  logic              ovf_clr
);

  os_state_e         state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] out_data_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              full_q, full_d;
  logic              ovf_q;

  logic              accept, hs;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [FCNT_W-1:0] fifo_count;

  // Full comes from registered state only, so a same-cycle handshake
  // cannot rescue a write presented while full.
  assign accept = OutPort_in && !full_q;
  assign hs     = (state_q == OS_VALID) && tx_ready;

  out_port_fifo #(
    .DATA_W  (DATA_W),
    .ENTRIES (DEPTH - 1)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (Bus_Data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The FIFO head always has priority over a bypass write to keep ordering.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    fifo_push = accept;
    case (state_q)
      OS_EMPTY: begin
        if (!fifo_empty) begin
          tx_data_d = fifo_rdata;
          fifo_pop  = 1'b1;
          state_d   = OS_VALID;
        end else if (accept) begin
          tx_data_d = Bus_Data;
          fifo_push = 1'b0;
          state_d   = OS_VALID;
        end
      end
      OS_VALID: begin
        if (hs) begin
          if (!fifo_empty) begin
            tx_data_d = fifo_rdata;
            fifo_pop  = 1'b1;
          end else if (accept) begin
            tx_data_d = Bus_Data;
            fifo_push = 1'b0;
          end else begin
            state_d = OS_EMPTY;
          end
        end
      end
      default: state_d = OS_EMPTY;
    endcase
  end

  always_comb begin
    case ({accept, hs})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    full_d = (occ_d == OCC_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= OS_EMPTY;
      tx_data_q  <= '0;
      out_data_q <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      occ_q     <= occ_d;
      full_q    <= full_d;
      if (accept) out_data_q <= Bus_Data;
      // Set wins over a simultaneous clear.
      if (OutPort_in && full_q) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

  // Occupancy is kept as its own register; it must always equal the FIFO
  // body plus the tx stage, and the body can never be pushed while full.
  always @(posedge clk) begin
    if (clr) begin
      assert (occ_q == OCC_W'(fifo_count) + OCC_W'(state_q == OS_VALID));
      assert (!(fifo_push && fifo_full && !fifo_pop));
    end
  end

  assign out_full         = full_q;
  assign Outport_Data_Out = out_data_q;
  assign tx_data          = tx_data_q;
  assign tx_valid         = (state_q == OS_VALID);
  assign occupancy        = occ_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_out_port_tx.sv
module tb_out_port_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          OutPort_in;
  logic [DW-1:0] Bus_Data;
  logic          out_full;
  logic [DW-1:0] Outport_Data_Out;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [2:0]    occupancy;
  logic          overflow;
  logic          ovf_clr;

  out_port_tx #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .clr              (clr),
    .OutPort_in       (OutPort_in),
    .Bus_Data         (Bus_Data),
    .out_full         (out_full),
    .Outport_Data_Out (Outport_Data_Out),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .occupancy        (occupancy),
    .overflow         (overflow),
    .ovf_clr          (ovf_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard: accepted words in order; its size is the expected occupancy.
  logic [DW-1:0] exp_q[$];
  logic          m_ovf;
  logic [DW-1:0] m_out;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          oc;
    int            occ;
    logic          full;
    logic          valid;
    logic [DW-1:0] txd;
    logic          ovf;
    logic [DW-1:0] outd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic w, input logic [DW-1:0] d, input logic r, input logic oc,
                     input int occ, input logic full, input logic valid,
                     input logic [DW-1:0] txd, input logic ovf, input logic [DW-1:0] outd);
    vec_t v;
    v.w = w; v.d = d; v.r = r; v.oc = oc; v.occ = occ; v.full = full;
    v.valid = valid; v.txd = txd; v.ovf = ovf; v.outd = outd;
    vq.push_back(v);
  endtask

  task automatic check_model();
    chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
    chk("out_full", 32'(out_full), 32'(exp_q.size() == DEPTH));
    chk("tx_valid", 32'(tx_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("tx_data_order", tx_data, exp_q[0]);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("outport_data", Outport_Data_Out, m_out);
  endtask

  // Drive one cycle of inputs (called at posedge+1), check the model at the
  // negedge, advance the model, and return at posedge+1.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic oc);
    logic mfull;
    OutPort_in = w; Bus_Data = d; tx_ready = r; ovf_clr = oc;
    @(negedge clk);
    check_model();
    mfull = (exp_q.size() == DEPTH);
    if (r && exp_q.size() > 0) void'(exp_q.pop_front());
    if (w && !mfull) begin
      exp_q.push_back(d);
      m_out = d;
    end
    if (w && mfull) m_ovf = 1'b1;
    else if (oc)    m_ovf = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_out = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_occ"},   32'(occupancy), 0);
    chk({tag, "_full"},  32'(out_full), 0);
    chk({tag, "_valid"}, 32'(tx_valid), 0);
    chk({tag, "_txd"},   tx_data, 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
    chk({tag, "_outd"},  Outport_Data_Out, 0);
  endtask

  initial begin
    OutPort_in = 0; Bus_Data = '0; tx_ready = 0; ovf_clr = 0;
    model_reset();
    clr = 1'b1;
    #2 clr = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b1;

    // w d r oc | occ full valid txd ovf outd
    add(1, 32'h1020FCAE, 1, 0, 1, 0, 1, 32'h1020FCAE, 0, 32'h1020FCAE);
    add(0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 32'h1020FCAE);
    add(1, 32'h1,        0, 0, 1, 0, 1, 32'h1,        0, 32'h1);
    add(1, 32'h2,        0, 0, 2, 0, 1, 32'h1,        0, 32'h2);
    add(1, 32'h3,        0, 0, 3, 0, 1, 32'h1,        0, 32'h3);
    add(1, 32'h4,        0, 0, 4, 1, 1, 32'h1,        0, 32'h4);
    add(1, 32'h5,        0, 0, 4, 1, 1, 32'h1,        1, 32'h4);
    add(0, 32'h0,        0, 0, 4, 1, 1, 32'h1,        1, 32'h4);
    add(0, 32'h0,        1, 0, 3, 0, 1, 32'h2,        1, 32'h4);
    add(0, 32'h0,        1, 0, 2, 0, 1, 32'h3,        1, 32'h4);
    add(0, 32'h0,        1, 0, 1, 0, 1, 32'h4,        1, 32'h4);
    add(0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        1, 32'h4);
    add(0, 32'h0,        0, 1, 0, 0, 0, 32'h0,        0, 32'h4);
    add(1, 32'hA0A00001, 0, 0, 1, 0, 1, 32'hA0A00001, 0, 32'hA0A00001);
    add(1, 32'hB0B00002, 0, 0, 2, 0, 1, 32'hA0A00001, 0, 32'hB0B00002);
    add(1, 32'hC0C00003, 1, 0, 2, 0, 1, 32'hB0B00002, 0, 32'hC0C00003);
    add(1, 32'hD0D00004, 1, 0, 2, 0, 1, 32'hC0C00003, 0, 32'hD0D00004);
    add(0, 32'h0,        1, 0, 1, 0, 1, 32'hD0D00004, 0, 32'hD0D00004);
    add(0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 32'hD0D00004);

    foreach (vq[i]) begin
      cycle(vq[i].w, vq[i].d, vq[i].r, vq[i].oc);
      chk($sformatf("vec%0d_occ", i),   32'(occupancy), 32'(vq[i].occ));
      chk($sformatf("vec%0d_full", i),  32'(out_full), 32'(vq[i].full));
      chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vq[i].valid));
      if (vq[i].valid) chk($sformatf("vec%0d_txd", i), tx_data, vq[i].txd);
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(vq[i].ovf));
      chk($sformatf("vec%0d_outd", i),  Outport_Data_Out, vq[i].outd);
    end

    // Overflow set and clear in the same cycle: set wins.
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h100 + 32'(i), 0, 0);
    cycle(1, 32'hDEAD0000, 0, 1);
    chk("ovf_set_wins", 32'(overflow), 1);
    cycle(0, 32'h0, 0, 1);
    chk("ovf_clear", 32'(overflow), 0);
    for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) cycle(0, 32'h0, 1, 0);
    chk("drain1_empty", 32'(exp_q.size()), 0);

    // Reset mid-operation with three words queued.
    for (int i = 0; i < 3; i++) cycle(1, 32'h200 + 32'(i), 0, 0);
    #2 clr = 1'b0;
    #1 chk_all_zero("midreset");
    model_reset();
    @(posedge clk); #1;
    clr = 1'b1;
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 1, 0);
    chk("post_reset_valid", 32'(tx_valid), 0);
    cycle(1, 32'h300, 0, 0);
    chk("post_reset_write", tx_data, 32'h300);
    cycle(0, 32'h0, 1, 0);

    // Random streaming; the model checks ordering and occupancy every cycle.
    for (int i = 0; i < 1000; i++) begin
      logic w, r, oc;
      w  = 1'($urandom_range(0, 1));
      r  = (i < 500) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 3) != 0);
      oc = 1'($urandom_range(0, 31) == 0);
      cycle(w, $urandom, r, oc);
    end
    for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) cycle(0, 32'h0, 1, 0);
    chk("final_drain_empty", 32'(exp_q.size()), 0);
    chk("final_valid", 32'(tx_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
